// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode 7-segment driver fed from a snapshot of the BCD digit bus.
// Optional leading-zero blanking is compiled in by defining LEADING_ZERO_BLANK_EN.
module seven_segment_scanner #(
    parameter int NUMBER_OF_DIGITS   = 4,
    parameter int REFRESH_DIVIDE     = 50000,
    parameter int ACTIVE_LOW_OUTPUTS = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          load,
    input  logic [NUMBER_OF_DIGITS*4-1:0] digitsIn,
    input  logic [NUMBER_OF_DIGITS-1:0]   dpIn,
    output logic [NUMBER_OF_DIGITS-1:0]   anodes,
    output logic [6:0]                    segments,
    output logic                          dp,
    output logic                          digitStrobe
);

    localparam int PRESCALE_W = (REFRESH_DIVIDE > 1) ? $clog2(REFRESH_DIVIDE) : 1;
    localparam int INDEX_W    = $clog2(NUMBER_OF_DIGITS);
    localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(REFRESH_DIVIDE - 1);
    localparam logic [INDEX_W-1:0]    INDEX_LAST    = INDEX_W'(NUMBER_OF_DIGITS - 1);
    localparam logic                  INVERT        = (ACTIVE_LOW_OUTPUTS != 0);

    localparam logic [NUMBER_OF_DIGITS-1:0] ANODE_MASK = {NUMBER_OF_DIGITS{INVERT}};
    localparam logic [6:0]                  SEG_MASK   = {7{INVERT}};

    // Segment pattern {g,f,e,d,c,b,a}, active-high; non-BCD codes show a dash.
    function automatic logic [6:0] decode_bcd(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'b0111111;
            4'd1:    pattern = 7'b0000110;
            4'd2:    pattern = 7'b1011011;
            4'd3:    pattern = 7'b1001111;
            4'd4:    pattern = 7'b1100110;
            4'd5:    pattern = 7'b1101101;
            4'd6:    pattern = 7'b1111101;
            4'd7:    pattern = 7'b0000111;
            4'd8:    pattern = 7'b1111111;
            4'd9:    pattern = 7'b1101111;
            default: pattern = 7'b1000000;
        endcase
        return pattern;
    endfunction

    logic [PRESCALE_W-1:0]         prescaler_reg, prescaler_next;
    logic [INDEX_W-1:0]            index_reg, index_next;
    logic [NUMBER_OF_DIGITS*4-1:0] snap_digits_reg, snap_digits_next;
    logic [NUMBER_OF_DIGITS-1:0]   snap_dp_reg, snap_dp_next;
    logic                          strobe_reg, strobe_next;
    logic [NUMBER_OF_DIGITS-1:0]   anodes_reg, anodes_next;
    logic [6:0]                    segments_reg, segments_next;
    logic                          dp_reg, dp_next;

    logic [3:0]                    snap_digit [NUMBER_OF_DIGITS];
    logic [NUMBER_OF_DIGITS-1:0]   anode_onehot;
    logic [NUMBER_OF_DIGITS-1:0]   blank_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUMBER_OF_DIGITS; gi++) begin : g_digit
            assign snap_digit[gi]   = snap_digits_reg[4*gi +: 4];
            assign anode_onehot[gi] = (index_reg == INDEX_W'(gi));
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blanked while it and everything above it is zero with no dp set.
    generate
        for (gi = 0; gi < NUMBER_OF_DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_lsd
                assign blank_vec[gi] = 1'b0;
            end else if (gi == NUMBER_OF_DIGITS - 1) begin : g_msd
                assign blank_vec[gi] = (snap_digit[gi] == 4'd0) && !snap_dp_reg[gi];
            end else begin : g_mid
                assign blank_vec[gi] = (snap_digit[gi] == 4'd0) && !snap_dp_reg[gi]
                                       && blank_vec[gi+1];
            end
        end
    endgenerate
`else
    assign blank_vec = '0;
`endif

    // Scan prescaler, index and strobe.
    always_comb begin
        prescaler_next = prescaler_reg;
        index_next     = index_reg;
        strobe_next    = 1'b0;
        if (enable) begin
            if (prescaler_reg == PRESCALE_LAST) begin
                prescaler_next = '0;
                strobe_next    = 1'b1;
                index_next     = (index_reg == INDEX_LAST) ? '0 : index_reg + 1'b1;
            end else begin
                prescaler_next = prescaler_reg + 1'b1;
            end
        end
    end

    always_comb begin
        snap_digits_next = snap_digits_reg;
        snap_dp_next     = snap_dp_reg;
        if (load) begin
            snap_digits_next = digitsIn;
            snap_dp_next     = dpIn;
        end
    end

    // Outputs reflect the pre-edge index and snapshot, so loads appear one edge later.
    always_comb begin
        anodes_next   = ANODE_MASK;
        segments_next = SEG_MASK;
        dp_next       = INVERT;
        if (enable) begin
            anodes_next   = anode_onehot ^ ANODE_MASK;
            segments_next = (blank_vec[index_reg] ? 7'd0 : decode_bcd(snap_digit[index_reg]))
                            ^ SEG_MASK;
            dp_next       = snap_dp_reg[index_reg] ^ INVERT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prescaler_reg   <= '0;
            index_reg       <= '0;
            snap_digits_reg <= '0;
            snap_dp_reg     <= '0;
            strobe_reg      <= 1'b0;
            anodes_reg      <= ANODE_MASK;
            segments_reg    <= SEG_MASK;
            dp_reg          <= INVERT;
        end else begin
            prescaler_reg   <= prescaler_next;
            index_reg       <= index_next;
            snap_digits_reg <= snap_digits_next;
            snap_dp_reg     <= snap_dp_next;
            strobe_reg      <= strobe_next;
            anodes_reg      <= anodes_next;
            segments_reg    <= segments_next;
            dp_reg          <= dp_next;
        end
    end

    assign anodes      = anodes_reg;
    assign segments    = segments_reg;
    assign dp          = dp_reg;
    assign digitStrobe = strobe_reg;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomised self-checking bench for seven_segment_scanner against a cycle-count display model.
// Honours LEADING_ZERO_BLANK_EN in the model when the design is built with it.
module tb_seven_segment_scanner;

    localparam int N  = 4;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   digits_in = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    anodes;
    logic [6:0]    segments;
    logic          dp;
    logic          digit_strobe;

    seven_segment_scanner #(
        .NUMBER_OF_DIGITS  (N),
        .REFRESH_DIVIDE    (RD),
        .ACTIVE_LOW_OUTPUTS(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .digitsIn   (digits_in),
        .dpIn       (dp_in),
        .anodes     (anodes),
        .segments   (segments),
        .dp         (dp),
        .digitStrobe(digit_strobe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: number of enabled edges since reset fully determines scan position.
    int          en_count = 0;
    logic [3:0]  m_digit [N];
    logic [N-1:0] m_dp = '0;
    logic [12:0] exp_vec;
    wire  [12:0] obs_vec = {anodes, segments, dp, digit_strobe};

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0: s = 7'b0111111;  4'd1: s = 7'b0000110;
            4'd2: s = 7'b1011011;  4'd3: s = 7'b1001111;
            4'd4: s = 7'b1100110;  4'd5: s = 7'b1101101;
            4'd6: s = 7'b1111101;  4'd7: s = 7'b0000111;
            4'd8: s = 7'b1111111;  4'd9: s = 7'b1101111;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    function automatic bit lz_blank(input int k);
        bit b;
        b = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (k >= 1) begin
            b = 1'b1;
            for (int j = k; j < N; j++)
                if (m_digit[j] != 4'd0 || m_dp[j]) b = 1'b0;
        end
`endif
        return b;
    endfunction

    // Drive one cycle, predict the outputs after the edge, and advance the model.
    task automatic step(input logic r, input logic en, input logic ld,
                        input logic [15:0] d, input logic [3:0] p);
        int idx;
        logic [N-1:0] onehot;
        logic [6:0] seg_ah;
        rst = r; enable = en; load = ld; digits_in = d; dp_in = p;
        if (!r || !en) begin
            exp_vec = {4'hF, 7'h7F, 1'b1, 1'b0};
        end else begin
            idx = (en_count / RD) % N;
            onehot = '0;
            onehot[idx] = 1'b1;
            seg_ah = lz_blank(idx) ? 7'd0 : seg_of(m_digit[idx]);
            exp_vec = {~onehot, ~seg_ah, ~m_dp[idx], (en_count % RD) == RD - 1};
        end
        @(posedge clk);
        if (!r) begin
            en_count = 0;
            for (int k = 0; k < N; k++) m_digit[k] = 4'd0;
            m_dp = '0;
        end else begin
            if (en) en_count++;
            if (ld) begin
                for (int k = 0; k < N; k++) m_digit[k] = d[4*k +: 4];
                m_dp = p;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 16'h1234, 4'hF);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL reset: got %b want %b", obs_vec, exp_vec);
            end
        end
        step(1'b1, 1'b1, 1'b0, 16'h0000, 4'h0);
        checks++;
        if (segments !== 7'b1000000 || anodes !== 4'hE) begin
            errors++;
            $display("FAIL reset_release: anodes %h seg %b want E 1000000", anodes, segments);
        end
        $display("reset: done, en_count=%0d", en_count);
    endtask

    task automatic test_scan_order();
        step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b0, 1'b1, 16'h9876, 4'h0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL scan_order cyc %0d: got %b want %b", i, obs_vec, exp_vec);
            end
        end
        $display("scan_order: loaded 9876, 20 cycles");
    endtask

    task automatic test_freeze();
        step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b0, 1'b1, 16'h4321, 4'h5);
        for (int i = 0; i < 41; i++) begin
            logic en;
            en = !(i >= 9 && i < 19);
            step(1'b1, en, 1'b0, 16'h0, 4'h0);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL freeze cyc %0d en %0b: got %b want %b", i, en, obs_vec, exp_vec);
            end
        end
        $display("freeze: 10-cycle pause mid digit 2");
    endtask

    task automatic test_nonbcd_dp();
        step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b1, 1'b1, 16'h00A0, 4'b0010);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL nonbcd_dp cyc %0d: got %b want %b", i, obs_vec, exp_vec);
            end
        end
        $display("nonbcd_dp: loaded 00A0 dp 0010");
    endtask

    task automatic test_load_collision();
        step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b1, 1'b1, 16'h1111, 4'h0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        // en_count is now 3: the next edge advances the index.
        step(1'b1, 1'b1, 1'b1, 16'h5555, 4'h0);
        checks++;
        if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL collision_edge: got %b want %b", obs_vec, exp_vec);
        end
        step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        checks++;
        if (segments !== 7'b0010010 || anodes !== 4'hD) begin
            errors++;
            $display("FAIL collision_next: anodes %h seg %b want D 0010010", anodes, segments);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL collision_after cyc %0d: got %b want %b", i, obs_vec, exp_vec);
            end
        end
        $display("load_collision: 5555 loaded on advance edge");
    endtask

    task automatic test_leading_zero();
        logic [3:0] dps [2];
        dps[0] = 4'b0000;
        dps[1] = 4'b0100;
        for (int t = 0; t < 2; t++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
            step(1'b1, 1'b0, 1'b1, 16'h0050, dps[t]);
            for (int i = 0; i < 17; i++) begin
                step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
                checks++;
                if (obs_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL leading_zero dp %b cyc %0d: got %b want %b",
                             dps[t], i, obs_vec, exp_vec);
                end
            end
            $display("leading_zero: 0050 dp %b", dps[t]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic r, en, ld;
            r  = ($urandom_range(0, 39) != 0);
            en = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 7) == 0);
            step(r, en, ld, 16'($urandom), 4'($urandom));
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL random cyc %0d rst %0b en %0b ld %0b: got %b want %b",
                         i, r, en, ld, obs_vec, exp_vec);
            end
        end
        $display("random: 400 cycles");
    endtask

    initial begin
        for (int k = 0; k < N; k++) m_digit[k] = 4'd0;
        test_reset();
        test_scan_order();
        test_freeze();
        test_nonbcd_dp();
        test_load_collision();
        test_leading_zero();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
